// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and word-index field positions.
package axil_pkg;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t AXIL_RESP_OKAY   = 2'b00;
    localparam axil_resp_t AXIL_RESP_SLVERR = 2'b10;

    localparam int AXIL_ADDR_IDX_MSB = 11;
    localparam int AXIL_ADDR_IDX_LSB = 2;
    localparam int AXIL_IDX_W        = AXIL_ADDR_IDX_MSB - AXIL_ADDR_IDX_LSB + 1;

endpackage

// File: rtl/axil_hold_slot.sv
// One-entry valid/ready capture register. Ready comes up on the first edge after
// reset, drops on handshake, and returns only when the owner clears the slot.
module axil_hold_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            in_ready <= 1'b0;
        end else if (in_valid && in_ready) begin
            full     <= 1'b1;
            in_ready <= 1'b0;
        end else if (clear) begin
            full     <= 1'b0;
            in_ready <= 1'b1;
        end else if (!full) begin
            in_ready <= 1'b1;
        end
    end

    // Payload needs no reset: it is only consumed while full is set.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/axil_register_slave.sv
// AXI4-Lite register bank: byte-strobed control registers plus read-only status
// words, independent single-outstanding write and read paths.
module axil_register_slave
    import axil_pkg::*;
#(
    parameter int          NUM_CTRL   = 8,
    parameter int          NUM_STATUS = 4,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [31:0]                    s_axil_awaddr,
    input  logic [2:0]                     s_axil_awprot,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [31:0]                    s_axil_wdata,
    input  logic [3:0]                     s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [31:0]                    s_axil_araddr,
    input  logic [2:0]                     s_axil_arprot,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    output logic [31:0]                    s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    output logic [NUM_CTRL-1:0][31:0]      ctrl_reg,
    output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
    input  logic [(NUM_STATUS > 0 ? NUM_STATUS : 1)-1:0][31:0] status_in
);

    localparam logic [AXIL_IDX_W:0] CTRL_END = (AXIL_IDX_W + 1)'(NUM_CTRL);

    logic                  aw_full, w_full, ar_full;
    logic [AXIL_IDX_W-1:0] aw_idx, ar_idx;
    logic [35:0]           w_slot;
    logic                  b_done, r_done, do_commit, do_read, wr_is_ctrl;
    logic [31:0]           rd_data;
    axil_resp_t            rd_resp;
    logic                  unused_bits;

    assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[31:AXIL_ADDR_IDX_MSB+1], s_axil_awaddr[AXIL_ADDR_IDX_LSB-1:0],
                           s_axil_araddr[31:AXIL_ADDR_IDX_MSB+1], s_axil_araddr[AXIL_ADDR_IDX_LSB-1:0]};

    assign b_done    = s_axil_bvalid && s_axil_bready;
    assign r_done    = s_axil_rvalid && s_axil_rready;
    assign do_commit = aw_full && w_full && !s_axil_bvalid;
    assign do_read   = ar_full && !s_axil_rvalid;
    assign wr_is_ctrl = {1'b0, aw_idx} < CTRL_END;

    axil_hold_slot #(.DATA_W(AXIL_IDX_W)) u_aw_slot (
        .clk(aclk), .rst(areset),
        .in_valid(s_axil_awvalid), .in_ready(s_axil_awready),
        .in_data(s_axil_awaddr[AXIL_ADDR_IDX_MSB:AXIL_ADDR_IDX_LSB]),
        .clear(b_done), .full(aw_full), .data(aw_idx)
    );

    axil_hold_slot #(.DATA_W(36)) u_w_slot (
        .clk(aclk), .rst(areset),
        .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
        .in_data({s_axil_wstrb, s_axil_wdata}),
        .clear(b_done), .full(w_full), .data(w_slot)
    );

    axil_hold_slot #(.DATA_W(AXIL_IDX_W)) u_ar_slot (
        .clk(aclk), .rst(areset),
        .in_valid(s_axil_arvalid), .in_ready(s_axil_arready),
        .in_data(s_axil_araddr[AXIL_ADDR_IDX_MSB:AXIL_ADDR_IDX_LSB]),
        .clear(r_done), .full(ar_full), .data(ar_idx)
    );

    // Write commit: slots stay full until the B handshake, so bvalid alone blocks a re-commit.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ctrl_reg      <= {NUM_CTRL{CTRL_RESET}};
            ctrl_wr_pulse <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= AXIL_RESP_OKAY;
        end else begin
            ctrl_wr_pulse <= '0;
            if (do_commit) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_is_ctrl ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (aw_idx == AXIL_IDX_W'(i)) begin
                        ctrl_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (w_slot[32+b]) begin
                                ctrl_reg[i][8*b +: 8] <= w_slot[8*b +: 8];
                            end
                        end
                    end
                end
            end else if (b_done) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_resp = AXIL_RESP_SLVERR;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (ar_idx == AXIL_IDX_W'(i)) begin
                rd_data = ctrl_reg[i];
                rd_resp = AXIL_RESP_OKAY;
            end
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (ar_idx == AXIL_IDX_W'(NUM_CTRL + i)) begin
                rd_data = status_in[i];
                rd_resp = AXIL_RESP_OKAY;
            end
        end
    end

    // Read response register: captures the pre-commit register value on a same-cycle write.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= AXIL_RESP_OKAY;
        end else if (do_read) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_data;
            s_axil_rresp  <= rd_resp;
        end else if (r_done) begin
            s_axil_rvalid <= 1'b0;
        end
    end

endmodule
